pcie_cfg_intr_responder: RTL
============================

// Module: pcie_cfg_intr_responder
// PURPOSE
//  Core-side responder for the PCIe cfg interrupt interface: accepts Legacy INTx, MSI and MSI-X
//  requests from an interrupt controller and returns sent/fail strobes.
//  Each accepted interrupt becomes one message record on a valid/ready stream toward the host model.
//  Used in the LLDMA emulation/loopback build in place of the hard PCIe core.
// PARAMETERS
//  RSP_LAT   4    cycles spent in LAT before a message is offered (>=1)
//  TIMEOUT   256  max cycles in OFFER waiting for msg_ready before MSI/MSI-X fail (>=1)
// PORTS
//  user_clk                    in   1   clock
//  user_reset                  in   1   reset, asynchronous, active-high
//  cfg_interrupt_int           in   4   INTA..INTD levels
//  cfg_interrupt_sent          out  1   1-cycle pulse, INTx message delivered
//  cfg_interrupt_msi_enable    in   1   MSI enabled
//  cfg_interrupt_msi_mmenable  in   3   allowed MSI vectors = 2**value (0..5)
//  cfg_interrupt_msi_int       in   32  MSI vector request bits
//  cfg_interrupt_msi_sent      out  1   1-cycle pulse, MSI delivered
//  cfg_interrupt_msi_fail      out  1   1-cycle pulse, MSI rejected
//  cfg_interrupt_msix_enable   in   1   MSI-X enabled
//  cfg_interrupt_msix_int      in   1   MSI-X request strobe
//  cfg_interrupt_msix_address  in   64  MSI-X address, sampled with strobe
//  cfg_interrupt_msix_data     in   32  MSI-X data, sampled with strobe
//  cfg_interrupt_msix_sent     out  1   1-cycle pulse, MSI-X delivered
//  cfg_interrupt_msix_fail     out  1   1-cycle pulse, MSI-X rejected
//  msg_valid                   out  1   message record valid
//  msg_ready                   in   1   host model accepts record
//  msg_type                    out  2   0=INTx 1=MSI 2=MSI-X
//  msg_addr                    out  64  MSI-X address, else 0
//  msg_data                    out  32  INTx: {28'b0,level}; MSI: vector index; MSI-X: data
//  err_overflow                out  1   sticky: MSI-X strobe while MSI-X slot full; cleared by reset only
//  stat_sent_cnt               out  16  see CONFIGURATION
//  stat_fail_cnt               out  16  see CONFIGURATION
// BEHAVIOUR
//  - Reset: all outputs, pending slots, counters and intx_q = 0; FSM=IDLE. Reset mid-operation
//    drops in-flight request; no sent/fail pulse is issued for it.
//  - Capture (1 cycle after request input):
//    - INTx: cfg_interrupt_int != intx_q sets leg_pend and latches level; changes while pending
//      overwrite the level (coalesced, one message).
//    - MSI: rising bits (msi_int & ~msi_int_q) OR into msi_pend[31:0].
//    - MSI-X: strobe with slot empty fills slot {addr,data}; slot full -> dropped, err_overflow=1.
//  - FSM IDLE->LAT: priority MSI-X > MSI > INTx; MSI serves lowest set bit of msi_pend and clears it.
//  - LAT: counts RSP_LAT cycles, then:
//    - MSI fail if !msi_enable or vector >= 2**mmenable.
//    - MSI-X fail if !msix_enable or address[1:0] != 0.
//    - Fail -> RESP(fail); otherwise -> OFFER.
//  - OFFER: msg_valid=1, fields stable until msg_valid&&msg_ready -> RESP(sent).
//    - MSI/MSI-X: TIMEOUT cycles without ready -> drop msg_valid, RESP(fail).
//    - INTx: no timeout.
//  - RESP: exactly one cycle; pulses the matching sent or fail; ->IDLE.
//  - Latency: request at cycle 0, msg_ready held 1 -> msg_valid at cycle RSP_LAT+2, sent at
//    RSP_LAT+3; fail by check at RSP_LAT+2.
//  - Simultaneous INTx, MSI and MSI-X captures are all held; served back-to-back by priority.
//  - Enable deasserting mid-OFFER does not abort; the check is only made in LAT.
// CONFIGURATION
//  PCIE_INTR_RSP_STATS_EN defined:
//    - stat_sent_cnt increments on every sent pulse (all types).
//    - stat_fail_cnt increments on every fail pulse.
//    - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
//  Undefined: both stat outputs tied to 0; no counter flops.
// TESTING
//  - MSI: enable=1, mmenable=3, msi_int=32'h4 for 1 cycle, ready=1 ->
//    msg_valid@6 type=1 data=2, msi_sent@7.
//  - MSI vector 9 with mmenable=3 -> no msg_valid; msi_fail pulse@6.
//  - MSI-X: addr=64'hAAAA_BBBB_CCCC_DDDD (addr[1:0]=1) -> msix_fail;
//    addr ...DDDC, data=32'hDEAD_BEEF -> msg data DEAD_BEEF, msix_sent.
//  - INTx 0->1 then 1->0 with ready=1 -> two records (data 1 then 0), two cfg_interrupt_sent pulses.
//  - Same-cycle MSI-X + MSI 32'h1 + INTx 1 -> record order type 2,1,0; ready=0 for 256 cycles
//    on MSI-X -> msix_fail.
//  - Reset asserted in OFFER -> msg_valid=0 next edge, no pulses; with STATS_EN, counts=0.

Source files
------------

// File: rtl/pcie_cfg_intr_responder_if.sv
// Message stream from the interrupt responder to the host model.
// master: the responder that offers records; slave: the host model that accepts them.
interface pcie_cfg_intr_responder_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_type;
    logic [63:0] msg_addr;
    logic [31:0] msg_data;

    modport master (
        output msg_valid,
        output msg_type,
        output msg_addr,
        output msg_data,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_type,
        input  msg_addr,
        input  msg_data,
        output msg_ready
    );
endinterface

// File: rtl/pcie_cfg_intr_responder.sv
// pcie_cfg_intr_responder: core-side stand-in for the hard PCIe core's cfg
// interrupt interface (INTx / MSI / MSI-X). Every accepted interrupt becomes one
// record on the msg stream and is answered with a one-cycle sent or fail strobe.
// Build macro PCIE_INTR_RSP_STATS_EN adds saturating 16-bit sent/fail counters;
// without it the stat outputs are tied to zero.
module pcie_cfg_intr_responder #(
    parameter int unsigned RSP_LAT = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        user_clk,
    input  logic        user_reset,
    input  logic [3:0]  cfg_interrupt_int,
    output logic        cfg_interrupt_sent,
    input  logic        cfg_interrupt_msi_enable,
    input  logic [2:0]  cfg_interrupt_msi_mmenable,
    input  logic [31:0] cfg_interrupt_msi_int,
    output logic        cfg_interrupt_msi_sent,
    output logic        cfg_interrupt_msi_fail,
    input  logic        cfg_interrupt_msix_enable,
    input  logic        cfg_interrupt_msix_int,
    input  logic [63:0] cfg_interrupt_msix_address,
    input  logic [31:0] cfg_interrupt_msix_data,
    output logic        cfg_interrupt_msix_sent,
    output logic        cfg_interrupt_msix_fail,
    pcie_cfg_intr_responder_if.master msg,
    output logic        err_overflow,
    output logic [15:0] stat_sent_cnt,
    output logic [15:0] stat_fail_cnt
);
    localparam int unsigned CNT_MAX = (RSP_LAT > TIMEOUT) ? RSP_LAT : TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, LAT, OFFER, RESP} state_e;
    typedef enum logic [1:0] {MT_INTX = 2'd0, MT_MSI = 2'd1, MT_MSIX = 2'd2} msg_type_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q;

    logic [3:0]  intx_q;
    logic        leg_pend;
    logic [3:0]  leg_level;
    logic [31:0] msi_int_q;
    logic [31:0] msi_pend;
    logic        msix_pend;
    logic [63:0] msix_addr_q;
    logic [31:0] msix_data_q;

    msg_type_e   cur_type;
    logic [63:0] cur_addr;
    logic [31:0] cur_data;
    logic        cur_fail, fail_d;

    logic        take_msix, take_msi, take_leg;
    logic [4:0]  msi_vec;
    logic [31:0] msi_clr;
    logic        chk_fail;
    logic        resp;

    // Lowest pending MSI vector is served first.
    always_comb begin
        msi_vec = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (msi_pend[i-1]) msi_vec = 5'(i - 1);
        end
    end

    assign msi_clr = take_msi ? (32'd1 << msi_vec) : '0;

    // Delivery checks evaluated on the last LAT cycle.
    always_comb begin
        chk_fail = 1'b0;
        case (cur_type)
            MT_MSI:  chk_fail = !cfg_interrupt_msi_enable ||
                                (cur_data >= (32'd1 << cfg_interrupt_msi_mmenable));
            MT_MSIX: chk_fail = !cfg_interrupt_msix_enable || (cur_addr[1:0] != 2'b00);
            default: chk_fail = 1'b0;
        endcase
    end

    // Request capture: INTx level changes, MSI rising bits, MSI-X single slot.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            intx_q       <= '0;
            leg_pend     <= 1'b0;
            leg_level    <= '0;
            msi_int_q    <= '0;
            msi_pend     <= '0;
            msix_pend    <= 1'b0;
            msix_addr_q  <= '0;
            msix_data_q  <= '0;
            err_overflow <= 1'b0;
        end else begin
            intx_q <= cfg_interrupt_int;
            // A new level change wins over a same-cycle service of the old one.
            if (cfg_interrupt_int != intx_q) begin
                leg_pend  <= 1'b1;
                leg_level <= cfg_interrupt_int;
            end else if (take_leg) begin
                leg_pend <= 1'b0;
            end
            msi_int_q <= cfg_interrupt_msi_int;
            msi_pend  <= (msi_pend & ~msi_clr) | (cfg_interrupt_msi_int & ~msi_int_q);
            if (take_msix) msix_pend <= 1'b0;
            // Slot occupancy is judged on the registered flag, so a strobe in the
            // cycle the slot is being served still counts as an overflow.
            if (cfg_interrupt_msix_int) begin
                if (msix_pend) begin
                    err_overflow <= 1'b1;
                end else begin
                    msix_pend   <= 1'b1;
                    msix_addr_q <= cfg_interrupt_msix_address;
                    msix_data_q <= cfg_interrupt_msix_data;
                end
            end
        end
    end

    // Service FSM next-state: pick by priority, wait, check, offer, respond.
    always_comb begin
        state_d   = state_q;
        take_msix = 1'b0;
        take_msi  = 1'b0;
        take_leg  = 1'b0;
        fail_d    = cur_fail;
        case (state_q)
            IDLE: begin
                if (msix_pend) begin
                    take_msix = 1'b1;
                    state_d   = LAT;
                end else if (|msi_pend) begin
                    take_msi = 1'b1;
                    state_d  = LAT;
                end else if (leg_pend) begin
                    take_leg = 1'b1;
                    state_d  = LAT;
                end
                if (state_d == LAT) fail_d = 1'b0;
            end
            LAT: begin
                if (cnt_q == CW'(RSP_LAT - 1)) begin
                    fail_d  = chk_fail;
                    state_d = chk_fail ? RESP : OFFER;
                end
            end
            OFFER: begin
                if (msg.msg_ready) begin
                    fail_d  = 1'b0;
                    state_d = RESP;
                end else if (cur_type != MT_INTX && cnt_q == CW'(TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, cycle counter and the record currently being served.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cur_fail <= 1'b0;
            cur_type <= MT_INTX;
            cur_addr <= '0;
            cur_data <= '0;
        end else begin
            state_q  <= state_d;
            cur_fail <= fail_d;
            if (state_d != state_q) cnt_q <= '0;
            else if (cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
            if (take_msix) begin
                cur_type <= MT_MSIX;
                cur_addr <= msix_addr_q;
                cur_data <= msix_data_q;
            end else if (take_msi) begin
                cur_type <= MT_MSI;
                cur_addr <= '0;
                cur_data <= {27'b0, msi_vec};
            end else if (take_leg) begin
                cur_type <= MT_INTX;
                cur_addr <= '0;
                cur_data <= {28'b0, leg_level};
            end
        end
    end

    assign resp                    = (state_q == RESP);
    assign cfg_interrupt_sent      = resp && (cur_type == MT_INTX);
    assign cfg_interrupt_msi_sent  = resp && (cur_type == MT_MSI)  && !cur_fail;
    assign cfg_interrupt_msi_fail  = resp && (cur_type == MT_MSI)  &&  cur_fail;
    assign cfg_interrupt_msix_sent = resp && (cur_type == MT_MSIX) && !cur_fail;
    assign cfg_interrupt_msix_fail = resp && (cur_type == MT_MSIX) &&  cur_fail;

    assign msg.msg_valid = (state_q == OFFER);
    assign msg.msg_type  = cur_type;
    assign msg.msg_addr  = cur_addr;
    assign msg.msg_data  = cur_data;

`ifdef PCIE_INTR_RSP_STATS_EN
    logic any_sent, any_fail;
    assign any_sent = cfg_interrupt_sent || cfg_interrupt_msi_sent || cfg_interrupt_msix_sent;
    assign any_fail = cfg_interrupt_msi_fail || cfg_interrupt_msix_fail;

    // Saturating delivery statistics.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            stat_sent_cnt <= '0;
            stat_fail_cnt <= '0;
        end else begin
            if (any_sent && stat_sent_cnt != '1) stat_sent_cnt <= stat_sent_cnt + 16'd1;
            if (any_fail && stat_fail_cnt != '1) stat_fail_cnt <= stat_fail_cnt + 16'd1;
        end
    end
`else
    assign stat_sent_cnt = '0;
    assign stat_fail_cnt = '0;
`endif
endmodule
